// File: rtl/shreg_rr_arbiter.sv
// Round-robin arbiter and write sequencer for one shared D-register bank (q/q_bar).
// Define SHREG_PARITY_EN to add the registered even-parity bit q_par and the par_err flag.
module shreg_rr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int IW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   wdata,
  output logic [N-1:0]         gnt,
  output logic                 done,
  output logic                 busy,
  output logic [IW-1:0]        owner,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     q_bar
`ifdef SHREG_PARITY_EN
  ,
  output logic                 q_par,
  output logic                 par_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACK   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     win;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     ptr_nxt;
  logic [IW-1:0]     pick_idx;
  logic              pick_found;
  logic [WIDTH-1:0]  slice [N];

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign slice[i] = wdata[i*WIDTH +: WIDTH];
  end

  // Search starts at ptr and wraps, so the requester just served is checked last.
  always_comb begin : pick
    int idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    idx        = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!pick_found && req[IW'(idx)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(idx);
      end
    end
  end

  assign ptr_nxt = (int'(win) == N - 1) ? '0 : win + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      win   <= '0;
      ptr   <= '0;
      q     <= '0;
      owner <= '0;
`ifdef SHREG_PARITY_EN
      q_par <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && pick_found) begin
        win <= pick_idx;
      end
      if (state == GRANT) begin
        q     <= slice[win];
        owner <= win;
        ptr   <= ptr_nxt;
`ifdef SHREG_PARITY_EN
        q_par <= ^slice[win];
`endif
      end
    end
  end

  // Unused encodings fall through the default and land back in IDLE.
  always_comb begin
    state_nxt = IDLE;
    gnt       = '0;
    done      = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = pick_found ? GRANT : IDLE;
      end
      GRANT: begin
        state_nxt = ACK;
        gnt[win]  = 1'b1;
        busy      = 1'b1;
      end
      ACK: begin
        state_nxt = IDLE;
        done      = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign q_bar = ~q;

`ifdef SHREG_PARITY_EN
  assign par_err = (q_par != ^q);
`endif

endmodule

// File: tb/tb_shreg_rr_arbiter.sv
// Directed self-checking bench for shreg_rr_arbiter (N=4, WIDTH=8).
// Outputs are sampled 1 ns after each rising edge; inputs change right after sampling.
module tb_shreg_rr_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;
  localparam int IW    = 2;

  logic               clk;
  logic               rst;
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] wdata;
  logic [N-1:0]       gnt;
  logic               done;
  logic               busy;
  logic [IW-1:0]      owner;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   q_bar;
`ifdef SHREG_PARITY_EN
  logic               q_par;
  logic               par_err;
`endif

  int total = 0;
  int bad   = 0;

  shreg_rr_arbiter #(.N(N), .WIDTH(WIDTH), .IW(IW)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .done   (done),
    .busy   (busy),
    .owner  (owner),
    .q      (q),
    .q_bar  (q_bar)
`ifdef SHREG_PARITY_EN
    ,
    .q_par  (q_par),
    .par_err(par_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst   = 1'b0;
    req   = '0;
    wdata = '0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < N; i++) wdata[i*WIDTH +: WIDTH] = 8'h50 + 8'(i);
    repeat (2) step();
    total++;
    if ({q, q_bar} !== {8'h00, 8'hFF}) begin
      bad++;
      $display("[TB] FAIL reset_q q=%h q_bar=%h want 00/ff", q, q_bar);
    end
    total++;
    if ({gnt, busy, done, owner} !== {4'b0000, 1'b0, 1'b0, 2'd0}) begin
      bad++;
      $display("[TB] FAIL reset_ctl gnt=%b busy=%b done=%b owner=%0d want 0000/0/0/0", gnt, busy, done, owner);
    end
    rst = 1'b1;
    step();
    total++;
    if ({gnt, busy} !== {4'b0001, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset_first_grant gnt=%b busy=%b want 0001/1", gnt, busy);
    end
    req = '0;
    repeat (3) step();
  endtask

  task automatic test_single_write;
    do_reset();
    wdata[2*WIDTH +: WIDTH] = 8'hA5;
    req = 4'b0100;
    step();
    total++;
    if ({gnt, busy, done} !== {4'b0100, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL single_grant gnt=%b busy=%b done=%b want 0100/1/0", gnt, busy, done);
    end
    req = '0;
    step();
    total++;
    if ({gnt, busy, done} !== {4'b0000, 1'b1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL single_ack gnt=%b busy=%b done=%b want 0000/1/1", gnt, busy, done);
    end
    total++;
    if ({q, q_bar, owner} !== {8'hA5, 8'h5A, 2'd2}) begin
      bad++;
      $display("[TB] FAIL single_data q=%h q_bar=%h owner=%0d want a5/5a/2", q, q_bar, owner);
    end
    wdata[2*WIDTH +: WIDTH] = 8'hFF;
    repeat (2) begin
      step();
      total++;
      if ({busy, done, q} !== {1'b0, 1'b0, 8'hA5}) begin
        bad++;
        $display("[TB] FAIL single_hold busy=%b done=%b q=%h want 0/0/a5", busy, done, q);
      end
    end
  endtask

  task automatic test_rotation;
    logic [N-1:0] exp_gnt;
    logic [7:0]   exp_q;
    do_reset();
    for (int i = 0; i < N; i++) wdata[i*WIDTH +: WIDTH] = 8'h10 + 8'(i);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_gnt = 4'b0001 << (t % 4);
      exp_q   = 8'h10 + 8'(t % 4);
      step();
      total++;
      if ({gnt, done} !== {exp_gnt, 1'b0}) begin
        bad++;
        $display("[TB] FAIL rot_grant t=%0d gnt=%b done=%b want %b/0", t, gnt, done, exp_gnt);
      end
      step();
      total++;
      if ({done, q, owner} !== {1'b1, exp_q, 2'(t % 4)}) begin
        bad++;
        $display("[TB] FAIL rot_ack t=%0d done=%b q=%h owner=%0d want 1/%h/%0d", t, done, q, owner, exp_q, t % 4);
      end
      step();
      total++;
      if ({busy, done, gnt} !== {1'b0, 1'b0, 4'b0000}) begin
        bad++;
        $display("[TB] FAIL rot_idle t=%0d busy=%b done=%b gnt=%b want 0/0/0000", t, busy, done, gnt);
      end
    end
    req = '0;
    repeat (3) step();
  endtask

  task automatic test_fairness_wrap;
    do_reset();
    for (int i = 0; i < N; i++) wdata[i*WIDTH +: WIDTH] = 8'h20 + 8'(i);
    req = 4'b1000;
    step();
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL wrap_first gnt=%b want 1000", gnt);
    end
    req = 4'b1001;
    step();
    total++;
    if ({owner, q} !== {2'd3, 8'h23}) begin
      bad++;
      $display("[TB] FAIL wrap_owner owner=%0d q=%h want 3/23", owner, q);
    end
    repeat (2) step();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("[TB] FAIL wrap_next gnt=%b want 0001", gnt);
    end
    repeat (3) step();
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("[TB] FAIL wrap_after gnt=%b want 1000", gnt);
    end
    req = '0;
    repeat (3) step();
  endtask

  task automatic test_mid_reset;
    do_reset();
    wdata[1*WIDTH +: WIDTH] = 8'h3C;
    req = 4'b0010;
    step();
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL mid_grant gnt=%b want 0010", gnt);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({q, q_bar, owner, gnt, busy, done} !== {8'h00, 8'hFF, 2'd0, 4'b0000, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL mid_abort q=%h q_bar=%h owner=%0d gnt=%b busy=%b done=%b want 00/ff/0/0000/0/0",
               q, q_bar, owner, gnt, busy, done);
    end
    step();
    total++;
    if ({done, q} !== {1'b0, 8'h00}) begin
      bad++;
      $display("[TB] FAIL mid_no_done done=%b q=%h want 0/00", done, q);
    end
    rst = 1'b1;
    step();
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("[TB] FAIL mid_regrant gnt=%b want 0010", gnt);
    end
    req = '0;
    step();
    total++;
    if ({done, q, owner} !== {1'b1, 8'h3C, 2'd1}) begin
      bad++;
      $display("[TB] FAIL mid_served done=%b q=%h owner=%0d want 1/3c/1", done, q, owner);
    end
    repeat (2) step();
  endtask

`ifdef SHREG_PARITY_EN
  task automatic test_parity;
    do_reset();
    total++;
    if ({q_par, par_err} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL par_reset q_par=%b par_err=%b want 0/0", q_par, par_err);
    end
    wdata[0*WIDTH +: WIDTH] = 8'h07;
    wdata[1*WIDTH +: WIDTH] = 8'h03;
    req = 4'b0001;
    step();
    req = '0;
    step();
    total++;
    if ({q, q_par, par_err} !== {8'h07, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL par_07 q=%h q_par=%b par_err=%b want 07/1/0", q, q_par, par_err);
    end
    step();
    req = 4'b0010;
    step();
    req = '0;
    step();
    total++;
    if ({q, q_par, par_err} !== {8'h03, 1'b0, 1'b0}) begin
      bad++;
      $display("[TB] FAIL par_03 q=%h q_par=%b par_err=%b want 03/0/0", q, q_par, par_err);
    end
    repeat (2) step();
  endtask
`endif

  initial begin
    rst   = 1'b0;
    req   = '0;
    wdata = '0;
    test_reset();
    test_single_write();
    test_rotation();
    test_fairness_wrap();
    test_mid_reset();
`ifdef SHREG_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
